programmable_freq_divider: RTL and testbench

- Run-time programmable integer clock divider: divides clk by N, 2 <= N <= 2^WIDTH-1.
- 50% duty cycle for both even and odd N. Odd N uses a negedge retiming stage.
- Successor to the fixed 2/3 divider: parametrised width, glitch-free divisor change at period boundary, enable, period-start tick, pending-update status.
- Sits in the clocking utilities; output drives slow-domain logic and bench observation.

---
 rtl/programmable_freq_divider.sv | 116 +++++++++++
 tb/tb_programmable_freq_divider.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/programmable_freq_divider.sv
// programmable_freq_divider
// Run-time programmable integer clock divider (N = 2 .. 2^WIDTH-1) with a
// 50% duty cycle for both even and odd N. Odd N uses a negedge retiming
// stage. Divisor updates are deferred to the period boundary, so the output
// never glitches.
module programmable_freq_divider #(
   parameter int WIDTH       = 4,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] div,
   input  logic             load,
   output logic [WIDTH-1:0] pos_count,
   output logic [WIDTH-1:0] neg_count,
   output logic             clk_out,
   output logic             tick,
   output logic             pending
);

   localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] C_TWO     = WIDTH'(2);
   localparam logic [WIDTH-1:0] C_DEFAULT = WIDTH'(DEFAULT_DIV);

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_pos_count;
   logic [WIDTH-1:0] r_neg_count;
   logic [WIDTH-1:0] r_n_act;
   logic [WIDTH-1:0] r_shadow;
   logic             r_clk_pos;
   logic             r_clk_neg;
   logic             r_tick;
   logic             r_pending;

   logic [WIDTH-1:0] w_div_coerced;
   logic [WIDTH-1:0] w_next_count;
   logic [WIDTH-1:0] w_next_n;
   logic [WIDTH-1:0] w_half;
   logic             w_wrap;

   // Next count, divisor in force for the next count, and its high-phase length
   always_comb begin
      w_div_coerced = (div < C_TWO) ? C_TWO : div;
      w_wrap        = (r_pos_count == (r_n_act - C_ONE));
      w_next_count  = w_wrap ? '0 : (r_pos_count + C_ONE);
      w_next_n      = r_n_act;
      // A same-cycle load takes priority over an already pending shadow value
      if ((r_state == ST_IDLE) || w_wrap) begin
         if (load) begin
            w_next_n = w_div_coerced;
         end else if (r_pending) begin
            w_next_n = r_shadow;
         end
      end
      // ceil(N/2) as (N>>1)+N[0] so that N = 2^WIDTH-1 cannot overflow
      w_half = (w_next_n >> 1) + {{(WIDTH-1){1'b0}}, w_next_n[0]};
   end

   // Posedge control: start, period counting, divisor shadowing, tick
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_pos_count <= '0;
         r_clk_pos   <= 1'b0;
         r_tick      <= 1'b0;
         r_pending   <= 1'b0;
         r_n_act     <= C_DEFAULT;
         r_shadow    <= C_DEFAULT;
      end else if (!en) begin
         r_tick <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_state     <= ST_RUN;
         r_pos_count <= '0;
         r_clk_pos   <= 1'b1;
         r_tick      <= 1'b1;
         r_n_act     <= w_next_n;
         r_pending   <= 1'b0;
      end else begin
         r_pos_count <= w_next_count;
         r_clk_pos   <= (w_next_count < w_half);
         r_tick      <= (w_next_count == '0);
         r_n_act     <= w_next_n;
         if (w_wrap) begin
            r_pending <= 1'b0;
         end else if (load) begin
            r_shadow  <= w_div_coerced;
            r_pending <= 1'b1;
         end
      end
   end

   // Negedge retiming stage: delays the phase by half a cycle for odd N
   always_ff @(negedge clk) begin
      if (reset) begin
         r_clk_neg   <= 1'b0;
         r_neg_count <= '0;
      end else if (en) begin
         r_clk_neg   <= r_clk_pos;
         r_neg_count <= r_pos_count;
      end
   end

   // Odd/even select only changes at a period boundary, where both phases are low
   assign clk_out   = r_n_act[0] ? (r_clk_pos & r_clk_neg) : r_clk_pos;
   assign tick      = r_tick & en;
   assign pos_count = r_pos_count;
   assign neg_count = r_neg_count;
   assign pending   = r_pending;

endmodule

// File: tb/tb_programmable_freq_divider.sv
// Directed self-checking bench for programmable_freq_divider (WIDTH=4, DEFAULT_DIV=3).
// Outputs are sampled 1 ns after each posedge and 1 ns after each negedge;
// inputs change 1 ns after a negedge.
module tb_programmable_freq_divider;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       load;
   logic [3:0] div;
   logic [3:0] pos_count;
   logic [3:0] neg_count;
   logic       clk_out;
   logic       tick;
   logic       pending;

   int total = 0;
   int bad   = 0;

   programmable_freq_divider #(
      .WIDTH       (4),
      .DEFAULT_DIV (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .div       (div),
      .load      (load),
      .pos_count (pos_count),
      .neg_count (neg_count),
      .clk_out   (clk_out),
      .tick      (tick),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   // clk_out just after the posedge of count k: even N rises with the posedge,
   // odd N only after the following negedge.
   function automatic logic exp_hi_p(input int n, input int k);
      int h;
      h = (n + 1) / 2;
      if ((n % 2) == 0) return (k < h);
      return (k > 0) && (k < h);
   endfunction

   // clk_out just after the negedge following count k
   function automatic logic exp_hi_n(input int n, input int k);
      return k < ((n + 1) / 2);
   endfunction

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         total++;
         if ({pos_count, tick, clk_out, pending} !== 7'b0) begin
            bad++;
            $display("FAIL reset_pos c=%0d got pos=%0d tick=%b out=%b pend=%b want all 0",
                     c, pos_count, tick, clk_out, pending);
         end
         @(negedge clk); #1;
         total++;
         if ({neg_count, clk_out} !== 5'b0) begin
            bad++;
            $display("FAIL reset_neg c=%0d got neg=%0d out=%b want 0 0", c, neg_count, clk_out);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_div3();
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if ({pos_count, tick, clk_out, pending} !== {4'(k), (k == 0), exp_hi_p(3, k), 1'b0}) begin
               bad++;
               $display("FAIL div3_pos k=%0d got pos=%0d tick=%b out=%b pend=%b want pos=%0d tick=%b out=%b pend=0",
                        k, pos_count, tick, clk_out, pending, k, (k == 0), exp_hi_p(3, k));
            end
            @(negedge clk); #1;
            total++;
            if ({neg_count, clk_out} !== {4'(k), exp_hi_n(3, k)}) begin
               bad++;
               $display("FAIL div3_neg k=%0d got neg=%0d out=%b want neg=%0d out=%b",
                        k, neg_count, clk_out, k, exp_hi_n(3, k));
            end
         end
      end
   endtask

   task automatic test_load_div4();
      logic ep;
      for (int k = 0; k < 3; k++) begin
         ep = (k >= 1);
         @(posedge clk); #1;
         total++;
         if ({pos_count, tick, clk_out, pending} !== {4'(k), (k == 0), exp_hi_p(3, k), ep}) begin
            bad++;
            $display("FAIL load4_old k=%0d got pos=%0d tick=%b out=%b pend=%b want pos=%0d tick=%b out=%b pend=%b",
                     k, pos_count, tick, clk_out, pending, k, (k == 0), exp_hi_p(3, k), ep);
         end
         @(negedge clk); #1;
         if (k == 0) begin load = 1'b1; div = 4'd4; end
         if (k == 1) load = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total++;
            if ({pos_count, tick, clk_out, pending} !== {4'(k), (k == 0), exp_hi_p(4, k), 1'b0}) begin
               bad++;
               $display("FAIL load4_new_pos k=%0d got pos=%0d tick=%b out=%b pend=%b want pos=%0d tick=%b out=%b pend=0",
                        k, pos_count, tick, clk_out, pending, k, (k == 0), exp_hi_p(4, k));
            end
            @(negedge clk); #1;
            total++;
            if ({neg_count, clk_out} !== {4'(k), exp_hi_n(4, k)}) begin
               bad++;
               $display("FAIL load4_new_neg k=%0d got neg=%0d out=%b want neg=%0d out=%b",
                        k, neg_count, clk_out, k, exp_hi_n(4, k));
            end
         end
      end
   endtask

   task automatic test_coerce();
      logic ep;
      // div=0 loaded on the wrap posedge: applies at once, pending never set
      load = 1'b1; div = 4'd0;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            total++;
            if ({pos_count, tick, clk_out, pending} !== {4'(k), (k == 0), exp_hi_p(2, k), 1'b0}) begin
               bad++;
               $display("FAIL div0_pos k=%0d got pos=%0d tick=%b out=%b pend=%b want pos=%0d tick=%b out=%b pend=0",
                        k, pos_count, tick, clk_out, pending, k, (k == 0), exp_hi_p(2, k));
            end
            @(negedge clk); #1;
            total++;
            if ({neg_count, clk_out} !== {4'(k), exp_hi_n(2, k)}) begin
               bad++;
               $display("FAIL div0_neg k=%0d got neg=%0d out=%b want neg=%0d out=%b",
                        k, neg_count, clk_out, k, exp_hi_n(2, k));
            end
            if (p == 0 && k == 0) load = 1'b0;
         end
      end
      // div=1 loaded mid-period: pending for one cycle, still N=2 afterwards
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 2; k++) begin
            ep = (p == 0) && (k == 1);
            @(posedge clk); #1;
            total++;
            if ({pos_count, tick, clk_out, pending} !== {4'(k), (k == 0), exp_hi_p(2, k), ep}) begin
               bad++;
               $display("FAIL div1_pos p=%0d k=%0d got pos=%0d tick=%b out=%b pend=%b want pos=%0d tick=%b out=%b pend=%b",
                        p, k, pos_count, tick, clk_out, pending, k, (k == 0), exp_hi_p(2, k), ep);
            end
            @(negedge clk); #1;
            if (p == 0 && k == 0) begin load = 1'b1; div = 4'd1; end
            if (p == 0 && k == 1) load = 1'b0;
         end
      end
      // div=15 on the wrap: maximum divisor, odd
      load = 1'b1; div = 4'd15;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         total++;
         if ({pos_count, tick, clk_out, pending} !== {4'(k), (k == 0), exp_hi_p(15, k), 1'b0}) begin
            bad++;
            $display("FAIL div15_pos k=%0d got pos=%0d tick=%b out=%b pend=%b want pos=%0d tick=%b out=%b pend=0",
                     k, pos_count, tick, clk_out, pending, k, (k == 0), exp_hi_p(15, k));
         end
         @(negedge clk); #1;
         total++;
         if ({neg_count, clk_out} !== {4'(k), exp_hi_n(15, k)}) begin
            bad++;
            $display("FAIL div15_neg k=%0d got neg=%0d out=%b want neg=%0d out=%b",
                     k, neg_count, clk_out, k, exp_hi_n(15, k));
         end
         if (k == 0) load = 1'b0;
      end
   endtask

   task automatic test_last_wins();
      logic ep;
      load = 1'b1; div = 4'd3;
      for (int k = 0; k < 3; k++) begin
         ep = (k >= 1);
         @(posedge clk); #1;
         total++;
         if ({pos_count, tick, clk_out, pending} !== {4'(k), (k == 0), exp_hi_p(3, k), ep}) begin
            bad++;
            $display("FAIL lastwin_old k=%0d got pos=%0d tick=%b out=%b pend=%b want pos=%0d tick=%b out=%b pend=%b",
                     k, pos_count, tick, clk_out, pending, k, (k == 0), exp_hi_p(3, k), ep);
         end
         @(negedge clk); #1;
         if (k == 0) div = 4'd5;
         if (k == 1) div = 4'd6;
         if (k == 2) load = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            total++;
            if ({pos_count, tick, clk_out, pending} !== {4'(k), (k == 0), exp_hi_p(6, k), 1'b0}) begin
               bad++;
               $display("FAIL lastwin_new_pos k=%0d got pos=%0d tick=%b out=%b pend=%b want pos=%0d tick=%b out=%b pend=0",
                        k, pos_count, tick, clk_out, pending, k, (k == 0), exp_hi_p(6, k));
            end
            @(negedge clk); #1;
            total++;
            if ({neg_count, clk_out} !== {4'(k), exp_hi_n(6, k)}) begin
               bad++;
               $display("FAIL lastwin_new_neg k=%0d got neg=%0d out=%b want neg=%0d out=%b",
                        k, neg_count, clk_out, k, exp_hi_n(6, k));
            end
         end
      end
   endtask

   task automatic test_enable();
      @(posedge clk); #1;
      total++;
      if ({pos_count, tick, clk_out} !== {4'd0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL en_start got pos=%0d tick=%b out=%b want pos=0 tick=1 out=1", pos_count, tick, clk_out);
      end
      @(negedge clk); #1;
      en = 1'b0; load = 1'b1; div = 4'd9;
      #1;
      total++;
      if (tick !== 1'b0) begin
         bad++;
         $display("FAIL en_tick_gate got tick=%b want 0", tick);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         total++;
         if ({pos_count, tick, clk_out, pending} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL en_freeze_pos c=%0d got pos=%0d tick=%b out=%b pend=%b want pos=0 tick=0 out=1 pend=0",
                     c, pos_count, tick, clk_out, pending);
         end
         @(negedge clk); #1;
         total++;
         if ({neg_count, clk_out} !== {4'd0, 1'b1}) begin
            bad++;
            $display("FAIL en_freeze_neg c=%0d got neg=%0d out=%b want neg=0 out=1", c, neg_count, clk_out);
         end
      end
      en = 1'b1; load = 1'b0;
      for (int i = 1; i < 12; i++) begin
         @(posedge clk); #1;
         total++;
         if ({pos_count, tick, clk_out, pending} !== {4'(i % 6), ((i % 6) == 0), exp_hi_p(6, i % 6), 1'b0}) begin
            bad++;
            $display("FAIL en_resume_pos i=%0d got pos=%0d tick=%b out=%b pend=%b want pos=%0d tick=%b out=%b pend=0",
                     i, pos_count, tick, clk_out, pending, i % 6, ((i % 6) == 0), exp_hi_p(6, i % 6));
         end
         @(negedge clk); #1;
         total++;
         if ({neg_count, clk_out} !== {4'(i % 6), exp_hi_n(6, i % 6)}) begin
            bad++;
            $display("FAIL en_resume_neg i=%0d got neg=%0d out=%b want neg=%0d out=%b",
                     i, neg_count, clk_out, i % 6, exp_hi_n(6, i % 6));
         end
      end
   endtask

   task automatic test_reset_mid();
      load = 1'b1; div = 4'd7;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         total++;
         if ({pos_count, tick, clk_out, pending} !== {4'(k), (k == 0), exp_hi_p(7, k), (k == 1)}) begin
            bad++;
            $display("FAIL rstmid_n7 k=%0d got pos=%0d tick=%b out=%b pend=%b want pos=%0d tick=%b out=%b pend=%b",
                     k, pos_count, tick, clk_out, pending, k, (k == 0), exp_hi_p(7, k), (k == 1));
         end
         @(negedge clk); #1;
         if (k == 0) div = 4'd5;
         if (k == 1) begin load = 1'b0; reset = 1'b1; end
      end
      @(posedge clk); #1;
      total++;
      if ({pos_count, tick, clk_out, pending} !== 7'b0) begin
         bad++;
         $display("FAIL rstmid_pos got pos=%0d tick=%b out=%b pend=%b want all 0", pos_count, tick, clk_out, pending);
      end
      @(negedge clk); #1;
      total++;
      if ({neg_count, clk_out} !== 5'b0) begin
         bad++;
         $display("FAIL rstmid_neg got neg=%0d out=%b want 0 0", neg_count, clk_out);
      end
      reset = 1'b0;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if ({pos_count, tick, clk_out, pending} !== {4'(k), (k == 0), exp_hi_p(3, k), 1'b0}) begin
               bad++;
               $display("FAIL rstmid_restart_pos k=%0d got pos=%0d tick=%b out=%b pend=%b want pos=%0d tick=%b out=%b pend=0",
                        k, pos_count, tick, clk_out, pending, k, (k == 0), exp_hi_p(3, k));
            end
            @(negedge clk); #1;
            total++;
            if ({neg_count, clk_out} !== {4'(k), exp_hi_n(3, k)}) begin
               bad++;
               $display("FAIL rstmid_restart_neg k=%0d got neg=%0d out=%b want neg=%0d out=%b",
                        k, neg_count, clk_out, k, exp_hi_n(3, k));
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      en    = 1'b1;
      load  = 1'b0;
      div   = 4'd0;
      test_reset();
      test_div3();
      test_load_div4();
      test_coerce();
      test_last_wins();
      test_enable();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
